race_launcher: RTL

RACE_LAUNCHER -- requirements
Module: race_launcher

---
 rtl/race_pkg.sv | 25 ++
 rtl/sync2.sv | 29 ++
 rtl/race_launcher.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// Shared definitions for the arbiter-PUF race launcher.
// Holds the launcher FSM state type, default parameter values and the
// Fibonacci LFSR tap mask used to step the challenge between races.
package race_pkg;

    localparam int unsigned CHAL_W_DEF      = 64;
    localparam int unsigned RESP_W_DEF      = 8;
    localparam int unsigned RECOVER_CYC_DEF = 4;
    localparam int unsigned SETTLE_CYC_DEF  = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    // Taps 63, 62, 60, 59 for a 64-bit challenge.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLaunch,
        StWait,
        StSettle,
        StSample,
        StDone
    } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset, clears both flops
//   d       - asynchronous input
//   q       - synchronized output (two clk cycles of latency)
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/race_launcher.sv
// Arbiter-PUF race launcher.
// Accepts a seed challenge, then runs RESP_W races: for each race it holds the
// arbiter in reset, raises launch, waits for the (synchronized) arbiter done,
// lets the result settle and shifts the winner bit into the response MSB-first.
// Between races the challenge advances one Fibonacci LFSR step. A race that
// never completes within TIMEOUT_CYC cycles contributes a 0 bit and sets
// resp_timeout.
// Ports:
//   clk, reset_n                       - clock, asynchronous active-low reset
//   req_valid/req_ready/req_challenge  - challenge request handshake
//   chal_out                           - challenge presented to the delay chains
//   launch                             - registered launch edge into both paths
//   arb_reset                          - registered active-high arbiter reset
//   arb_done, arb_out                  - asynchronous arbiter result inputs
//   resp_valid/resp_ready/resp_data    - response handshake
//   resp_timeout                       - at least one race of the response timed out
module race_launcher
    import race_pkg::*;
#(
    parameter int unsigned CHAL_W      = CHAL_W_DEF,
    parameter int unsigned RESP_W      = RESP_W_DEF,
    parameter int unsigned RECOVER_CYC = RECOVER_CYC_DEF,
    parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CHAL_W-1:0] req_challenge,

    output logic [CHAL_W-1:0] chal_out,
    output logic              launch,
    output logic              arb_reset,

    input  logic              arb_done,
    input  logic              arb_out,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_timeout
);

    // One shared phase counter covers SETUP, WAIT and SETTLE.
    localparam int unsigned CNT_MAX_A = (RECOVER_CYC > SETTLE_CYC) ? RECOVER_CYC : SETTLE_CYC;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W     = $clog2(RESP_W + 1);

    localparam logic [CHAL_W-1:0] TAPS = CHAL_W'(LFSR_TAPS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic                timeout_q, timeout_d;
    logic                race_to_q, race_to_d;
    logic                launch_q, launch_d;
    logic                arb_reset_q, arb_reset_d;

    logic                done_sync;
    logic                out_sync;
    logic                sample_bit;
    logic [CHAL_W-1:0]   lfsr_next;

    sync2 u_sync_done (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (arb_done),
        .q       (done_sync)
    );

    sync2 u_sync_out (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (arb_out),
        .q       (out_sync)
    );

    // No all-zero correction: a zero challenge stays zero.
    assign lfsr_next  = {chal_q[CHAL_W-2:0], ^(chal_q & TAPS)};
    assign sample_bit = race_to_q ? 1'b0 : out_sync;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        chal_d    = chal_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        race_to_d = race_to_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    chal_d    = req_challenge;
                    bit_cnt_d = '0;
                    resp_d    = '0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == CNT_W'(RECOVER_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StLaunch;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLaunch: begin
                cnt_d     = '0;
                race_to_d = 1'b0;
                state_d   = StWait;
            end
            StWait: begin
                if (done_sync) begin
                    cnt_d   = '0;
                    state_d = StSettle;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    cnt_d     = '0;
                    race_to_d = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StSample;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSample: begin
                resp_d = {resp_q[RESP_W-2:0], sample_bit};
                if (bit_cnt_q == BIT_W'(RESP_W - 1)) begin
                    state_d = StDone;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    chal_d    = lfsr_next;
                    cnt_d     = '0;
                    state_d   = StSetup;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs into the delay chains are decoded from the next state and
        // registered, so they change only on clock edges.
        launch_d    = (state_d == StLaunch) || (state_d == StWait) ||
                      (state_d == StSettle) || (state_d == StSample);
        arb_reset_d = !launch_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            chal_q      <= '0;
            resp_q      <= '0;
            timeout_q   <= 1'b0;
            race_to_q   <= 1'b0;
            launch_q    <= 1'b0;
            arb_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            chal_q      <= chal_d;
            resp_q      <= resp_d;
            timeout_q   <= timeout_d;
            race_to_q   <= race_to_d;
            launch_q    <= launch_d;
            arb_reset_q <= arb_reset_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign resp_valid   = (state_q == StDone);
    assign chal_out     = chal_q;
    assign launch       = launch_q;
    assign arb_reset    = arb_reset_q;
    assign resp_data    = resp_q;
    assign resp_timeout = timeout_q;

endmodule
